// File: rtl/frame_writer_pkg.sv
// Shared types and constants for the frame writer: FSM states, pattern selects, bar colours.
// Latency: n/a (package).
// Backpressure: n/a (package).
package frame_writer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_KICK     = 3'd1,
        ST_WAIT_RDY = 3'd2,
        ST_WRITE    = 3'd3,
        ST_GAP      = 3'd4
    } fw_state_e;

    localparam logic [1:0] PAT_BARS  = 2'd0;
    localparam logic [1:0] PAT_GRAD  = 2'd1;
    localparam logic [1:0] PAT_CHECK = 2'd2;
    localparam logic [1:0] PAT_SOLID = 2'd3;

    localparam logic [15:0] COL_WHITE   = 16'hFFFF;
    localparam logic [15:0] COL_YELLOW  = 16'hFFE0;
    localparam logic [15:0] COL_CYAN    = 16'h07FF;
    localparam logic [15:0] COL_GREEN   = 16'h07E0;
    localparam logic [15:0] COL_MAGENTA = 16'hF81F;
    localparam logic [15:0] COL_RED     = 16'hF800;
    localparam logic [15:0] COL_BLUE    = 16'h001F;
    localparam logic [15:0] COL_BLACK   = 16'h0000;

    // Bar index 0..7 runs left to right across the line.
    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = COL_WHITE;
            3'd1:    c = COL_YELLOW;
            3'd2:    c = COL_CYAN;
            3'd3:    c = COL_GREEN;
            3'd4:    c = COL_MAGENTA;
            3'd5:    c = COL_RED;
            3'd6:    c = COL_BLUE;
            default: c = COL_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/frame_writer_pattern_gen.sv
// Combinational RGB565 test-pattern generator from pixel coordinates.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output simply follows x/y/sel/solid.
module pattern_gen
    import frame_writer_pkg::*;
#(
    parameter int H_ACTIVE = 1024,
    parameter int XW       = 10,
    parameter int YW       = 10
) (
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  logic [1:0]    sel,
    input  logic [15:0]   solid,
    output logic [15:0]   rgb565
);

    localparam int BAR_W = H_ACTIVE / 8;

    logic [31:0] xe;
    logic [31:0] ye;
    logic [4:0]  grad_rb;
    logic [5:0]  grad_g;
    logic        check_bit;
    logic [2:0]  bar_idx;

    // Zero-extend coordinates so bit picks above the coordinate width read as 0 on small frames.
    always_comb begin
        xe        = 32'(x);
        ye        = 32'(y);
        grad_rb   = 5'(xe >> 5);
        grad_g    = 6'(xe >> 4);
        check_bit = 1'((xe >> 5) ^ (ye >> 5));
        bar_idx   = 3'(xe / BAR_W);
    end

    // Pattern select.
    always_comb begin
        rgb565 = 16'h0000;
        case (sel)
            PAT_BARS:  rgb565 = bar_color(bar_idx);
            PAT_GRAD:  rgb565 = {grad_rb, grad_g, grad_rb};
            PAT_CHECK: rgb565 = check_bit ? 16'hFFFF : 16'h0000;
            default:   rgb565 = solid;
        endcase
    end

endmodule

// File: rtl/frame_writer.sv
// Frame source: kicks the SDRAM write arbiter, then streams one RGB565 test-pattern frame (macro FRAME_WRITER_SCROLL_EN adds scrolling).
// Latency: first word TOGGLE_HOLD+1 cycles after kickoff once mem_rdy_to_wr is high; mem_wr_req/mem_din are combinational.
// Backpressure: mem_wr_req follows mem_rdy_to_wr in the same cycle; x/y hold while it is low.
module frame_writer
    import frame_writer_pkg::*;
#(
    parameter int H_ACTIVE    = 1024,
    parameter int V_ACTIVE    = 768,
    parameter int TOGGLE_HOLD = 8,
    parameter int GAP_CYCLES  = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] solid_color,
    input  logic        mem_rdy,
    input  logic        mem_rdy_to_wr,
    output logic        mem_toggle,
    output logic        mem_wr_req,
    output logic [15:0] mem_din,
    output logic        busy,
    output logic        frame_done,
    output logic [7:0]  frame_cnt
);

    localparam int XW = $clog2(H_ACTIVE);
    localparam int YW = $clog2(V_ACTIVE);
    // The gap also serves as the toggle-low hold, so it never runs shorter than TOGGLE_HOLD.
    localparam int GAP_LEN = (GAP_CYCLES > TOGGLE_HOLD) ? GAP_CYCLES : TOGGLE_HOLD;
    localparam int CW      = $clog2(GAP_LEN + 1);
    localparam logic [XW-1:0] X_LAST   = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] KICK_END = CW'(TOGGLE_HOLD - 1);
    localparam logic [CW-1:0] GAP_END  = CW'(GAP_LEN - 1);

    fw_state_e      state_q, state_d;
    logic [XW-1:0]  x_q, x_d;
    logic [YW-1:0]  y_q, y_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     sel_q, sel_d;
    logic [15:0]    solid_q, solid_d;
    logic           frame_done_q, frame_done_d;
    logic           accept;
    logic [XW-1:0]  x_eff;
    logic [15:0]    pix;

    assign accept     = (state_q == ST_WRITE) && mem_rdy_to_wr;
    assign mem_wr_req = accept;
    assign mem_toggle = (state_q == ST_KICK);
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = frame_done_q;
    // Gate the word outside WRITE so idle/reset present an all-zero bus.
    assign mem_din    = (state_q == ST_WRITE) ? pix : 16'h0000;

    // Next-state, pixel counters and pattern latch.
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        solid_d      = solid_q;
        frame_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && mem_rdy) begin
                    state_d = ST_KICK;
                    sel_d   = pattern_sel;
                    solid_d = solid_color;
                    x_d     = '0;
                    y_d     = '0;
                    cnt_d   = '0;
                end
            end
            ST_KICK: begin
                if (cnt_q == KICK_END) begin
                    state_d = ST_WAIT_RDY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_WAIT_RDY: begin
                if (mem_rdy_to_wr) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (accept) begin
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        if (y_q == Y_LAST) begin
                            y_d          = '0;
                            frame_done_d = 1'b1;
                            cnt_d        = '0;
                            state_d      = ST_GAP;
                        end else begin
                            y_d = y_q + YW'(1);
                        end
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_END) begin
                    cnt_d = '0;
                    if (start && mem_rdy) begin
                        state_d = ST_KICK;
                        sel_d   = pattern_sel;
                        solid_d = solid_color;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            cnt_q        <= '0;
            sel_q        <= PAT_BARS;
            solid_q      <= 16'h0000;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            solid_q      <= solid_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef FRAME_WRITER_SCROLL_EN
    logic [7:0] frame_cnt_q, frame_cnt_d;

    // Completed-frame counter; bumps with the frame_done pulse and wraps at 256.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_done_d) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    // Frame counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= 8'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    // Shift the image one pixel per completed frame, wrapping within the line.
    assign x_eff     = x_q + XW'(frame_cnt_q);
`else
    assign frame_cnt = 8'd0;
    assign x_eff     = x_q;
`endif

    pattern_gen #(
        .H_ACTIVE (H_ACTIVE),
        .XW       (XW),
        .YW       (YW)
    ) u_pattern_gen (
        .x      (x_eff),
        .y      (y_q),
        .sel    (sel_q),
        .solid  (solid_q),
        .rgb565 (pix)
    );

endmodule

// File: tb/tb_frame_writer.sv
// Randomised self-checking bench for frame_writer: a small 16x4 instance for control/timing and a 64x64 one for patterns.
// Expected words come from a coordinate-level pattern model; timing from the kick/gap cycle rules.
// Inputs change just after the falling edge; outputs are sampled 1 ns later.
module tb_frame_writer;

    localparam int H1 = 16, V1 = 4,  TH1 = 8, GAP1 = 64;
    localparam int H2 = 64, V2 = 64, TH2 = 4, GAP2 = 8;
`ifdef FRAME_WRITER_SCROLL_EN
    localparam int SCROLL = 1;
`else
    localparam int SCROLL = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [15:0] solid_color = 16'h0000;
    logic        mem_rdy = 1'b0, mem_rdy_to_wr = 1'b0;

    logic        tog_a, req_a, busy_a, done_a;
    logic [15:0] din_a;
    logic [7:0]  cnt_a;
    logic        tog_b, req_b, busy_b, done_b;
    logic [15:0] din_b;
    logic [7:0]  cnt_b;

    frame_writer #(.H_ACTIVE(H1), .V_ACTIVE(V1), .TOGGLE_HOLD(TH1), .GAP_CYCLES(GAP1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .pattern_sel(pattern_sel), .solid_color(solid_color),
        .mem_rdy(mem_rdy), .mem_rdy_to_wr(mem_rdy_to_wr), .mem_toggle(tog_a), .mem_wr_req(req_a),
        .mem_din(din_a), .busy(busy_a), .frame_done(done_a), .frame_cnt(cnt_a));

    frame_writer #(.H_ACTIVE(H2), .V_ACTIVE(V2), .TOGGLE_HOLD(TH2), .GAP_CYCLES(GAP2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .pattern_sel(pattern_sel), .solid_color(solid_color),
        .mem_rdy(mem_rdy), .mem_rdy_to_wr(mem_rdy_to_wr), .mem_toggle(tog_b), .mem_wr_req(req_b),
        .mem_din(din_b), .busy(busy_b), .frame_done(done_b), .frame_cnt(cnt_b));

    logic        which = 1'b0;
    logic        s_toggle, s_req, s_busy, s_done;
    logic [15:0] s_din;
    logic [7:0]  s_cnt;
    assign s_toggle = which ? tog_b  : tog_a;
    assign s_req    = which ? req_b  : req_a;
    assign s_busy   = which ? busy_b : busy_a;
    assign s_done   = which ? done_b : done_a;
    assign s_din    = which ? din_b  : din_a;
    assign s_cnt    = which ? cnt_b  : cnt_a;

    int checks = 0;
    int failures = 0;
    int frames_a = 0, frames_b = 0;

    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];
    int tog_n, first_tog, first_acc, last_acc, done_cyc, done_n, viol;
    bit timed_out;

    // Pattern model written from the coordinate rules.
    function automatic logic [15:0] exp_word(int sel, logic [15:0] solid, int x, int y, int fc, int h);
        logic [15:0] bars [8];
        int xe, r, g;
        bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
        xe = (x + (fc % 256) * SCROLL) % h;
        case (sel)
            0: return bars[xe / (h / 8)];
            1: begin
                r = (xe / 32) % 32;
                g = (xe / 16) % 64;
                return 16'(r * 2048 + g * 32 + r);
            end
            2: return ((((xe / 32) % 2) ^ ((y / 32) % 2)) != 0) ? 16'hFFFF : 16'h0000;
            default: return solid;
        endcase
    endfunction

    function automatic int exp_cnt(int f);
        return (f % 256) * SCROLL;
    endfunction

    task automatic build_exp(int sel, logic [15:0] solid, int h, int v, int fc);
        exp_q.delete();
        for (int y = 0; y < v; y++)
            for (int x = 0; x < h; x++)
                exp_q.push_back(exp_word(sel, solid, x, y, fc, h));
    endtask

    task automatic set_start(logic v);
        if (which) start_b = v; else start_a = v;
    endtask

    // Drive one frame and record what the DUT did; returns one cycle after frame_done first appears.
    task automatic run_frame(int pct, int drop_at, int budget);
        got_q.delete();
        tog_n = 0; first_tog = -1; first_acc = -1; last_acc = -1;
        done_cyc = -1; done_n = 0; viol = 0; timed_out = 1'b1;
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            mem_rdy_to_wr = ($urandom_range(99) < pct);
            set_start((drop_at < 0) || (got_q.size() < drop_at));
            #1;
            if (s_toggle) begin tog_n++; if (first_tog < 0) first_tog = cyc; end
            if (s_req && !mem_rdy_to_wr) viol++;
            if (s_req) begin got_q.push_back(s_din); if (first_acc < 0) first_acc = cyc; last_acc = cyc; end
            if (s_done) begin done_n++; if (done_cyc < 0) done_cyc = cyc; end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin timed_out = 1'b0; break; end
        end
    endtask

    task automatic wait_idle(int limit, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk); #1;
            if (!s_busy) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        which = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({tog_a, req_a, din_a, busy_a, done_a, cnt_a} !== 28'd0) begin
            failures++; $display("FAIL reset_outputs got=%h want=0", {tog_a, req_a, din_a, busy_a, done_a, cnt_a});
        end
        @(negedge clk); rst_n = 1'b1; start_a = 1'b1; mem_rdy = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk); #1;
            checks++;
            if (tog_a !== 1'b0 || busy_a !== 1'b0) begin
                failures++; $display("FAIL no_mem_rdy cyc=%0d toggle=%b busy=%b want 0/0", c, tog_a, busy_a);
            end
        end
    endtask

    task automatic test_bars();
        which = 1'b0; pattern_sel = 2'd0; mem_rdy = 1'b1;
        run_frame(100, -1, 500);
        build_exp(0, 16'h0, H1, V1, frames_a);
        frames_a++;
        checks++; if (timed_out) begin failures++; $display("FAIL bars_timeout got=no frame_done want=frame_done"); end
        checks++; if (tog_n != TH1) begin failures++; $display("FAIL bars_toggle_len got=%0d want=%0d", tog_n, TH1); end
        checks++; if (first_acc - first_tog != TH1 + 1) begin
            failures++; $display("FAIL bars_kick_latency got=%0d want=%0d", first_acc - first_tog, TH1 + 1);
        end
        checks++; if (got_q.size() != exp_q.size()) begin
            failures++; $display("FAIL bars_count got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL bars_word[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (done_cyc != last_acc + 1 || done_n != 1) begin
            failures++; $display("FAIL bars_done got=cyc%0d/len%0d want=cyc%0d/len1", done_cyc, done_n, last_acc + 1);
        end
        checks++; if (s_cnt !== 8'(exp_cnt(frames_a))) begin
            failures++; $display("FAIL bars_frame_cnt got=%0d want=%0d", s_cnt, exp_cnt(frames_a));
        end
    endtask

    // Continues from test_bars: start and mem_rdy_to_wr stay high through the gap.
    task automatic test_gap();
        int k = 2;
        bit kicked = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk); mem_rdy_to_wr = 1'b1; #1; k++;
            if (s_toggle) begin kicked = 1'b1; break; end
            checks++;
            if (s_req !== 1'b0) begin failures++; $display("FAIL gap_req k=%0d got=%b want=0", k, s_req); end
        end
        checks++;
        if (!kicked || k != GAP1 + 1) begin
            failures++; $display("FAIL gap_kick_at got=%0d want=%0d", kicked ? k : -1, GAP1 + 1);
        end
    endtask

    task automatic test_start_drop();
        int extra_tog = 0;
        bit ok;
        run_frame(100, 10, 500);
        build_exp(0, 16'h0, H1, V1, frames_a);
        frames_a++;
        checks++; if (got_q.size() != exp_q.size() || timed_out) begin
            failures++; $display("FAIL drop_count got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL drop_word[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
        end
        for (int c = 0; c < 200; c++) begin
            @(negedge clk); #1;
            if (s_toggle) extra_tog++;
        end
        checks++; if (extra_tog != 0) begin failures++; $display("FAIL drop_second_kick got=%0d want=0", extra_tog); end
        checks++; if (s_busy !== 1'b0) begin failures++; $display("FAIL drop_idle busy got=%b want=0", s_busy); end
        wait_idle(10, ok);
    endtask

    task automatic test_throttled(logic w, int sel, int pct, int h, int v, int budget);
        bit ok;
        which = w; pattern_sel = 2'(sel); solid_color = 16'($urandom);
        run_frame(pct, 1, budget);
        build_exp(sel, solid_color, h, v, w ? frames_b : frames_a);
        if (w) frames_b++; else frames_a++;
        checks++; if (timed_out || got_q.size() != exp_q.size()) begin
            failures++; $display("FAIL thr_count sel=%0d got=%0d want=%0d", sel, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL thr_word sel=%0d [%0d] got=%h want=%h", sel, i, got_q[i], exp_q[i]);
            end
        end
        checks++; if (viol != 0) begin failures++; $display("FAIL thr_req_without_rdy got=%0d want=0", viol); end
        checks++; if (s_cnt !== 8'(exp_cnt(w ? frames_b : frames_a))) begin
            failures++; $display("FAIL thr_frame_cnt got=%0d want=%0d", s_cnt, exp_cnt(w ? frames_b : frames_a));
        end
        wait_idle(GAP1 + 20, ok);
        checks++; if (!ok) begin failures++; $display("FAIL thr_return_idle got=busy want=idle"); end
    endtask

    task automatic test_reset_midframe();
        int n = 0;
        which = 1'b0; pattern_sel = 2'd0; mem_rdy = 1'b1;
        for (int c = 0; c < 500 && n < 20; c++) begin
            @(negedge clk); start_a = 1'b1; mem_rdy_to_wr = 1'b1; #1;
            if (req_a) n++;
        end
        checks++; if (n != 20) begin failures++; $display("FAIL rstmid_reach got=%0d want=20", n); end
        @(negedge clk); rst_n = 1'b0; start_a = 1'b0; #1;
        checks++;
        if ({tog_a, req_a, din_a, busy_a, done_a, cnt_a} !== 28'd0) begin
            failures++; $display("FAIL rstmid_outputs got=%h want=0", {tog_a, req_a, din_a, busy_a, done_a, cnt_a});
        end
        frames_a = 0; frames_b = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_frame(100, 1, 500);
        build_exp(0, 16'h0, H1, V1, 0);
        frames_a++;
        checks++; if (got_q.size() != exp_q.size() || timed_out) begin
            failures++; $display("FAIL rstmid_count got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rstmid_word[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        bit ok;
        test_reset();
        test_bars();
        test_gap();
        test_start_drop();
        test_throttled(1'b0, 2, 50, H1, V1, 2000);
        test_throttled(1'b0, 3, 70, H1, V1, 2000);
        test_reset_midframe();
        wait_idle(GAP1 + 20, ok);
        test_throttled(1'b1, 1, 80, H2, V2, 12000);
        test_throttled(1'b1, 2, 80, H2, V2, 12000);
        test_throttled(1'b1, 0, 90, H2, V2, 12000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
